aemb2_iwb_fetch: RTL and testbench
==================================

Name: aemb2_iwb_fetch

Overview:
- Instruction-bus front end, directly upstream of the branch/PC unit.
- Accepts the fetch address generated by the PC unit and runs a classic single-beat Wishbone read on the instruction bus.
- Registers the returned instruction word.
- Generates the pipeline enable (ena) and thread phase (pha) that clock the PC unit and the rest of the core.
- Tolerates bus wait states, external data-side holds and a dead slave (timeout with NOP injection).

Parameters:
- IWB, 32, instruction address width; addresses are word addresses [IWB-1:2].
- TMO, 16, maximum wait cycles for iwb_ack_i before abort; 0 disables the timeout; must be in the range 0..255.
- NOP, 32'h80000000, instruction word injected on timeout (OR r0,r0,r0).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-low
- fet_adr_i  in  IWB-2  fetch word address from the PC unit
- fet_req_i  in  1  fetch request; sampled only in IDLE
- hld_i  in  1  external stall (e.g. data bus busy); blocks ena_o
- iwb_adr_o  out  IWB-2  Wishbone address
- iwb_stb_o  out  1  Wishbone strobe/cycle
- iwb_wre_o  out  1  Wishbone write enable; constant 0
- iwb_sel_o  out  4  byte selects; constant 4'hF
- iwb_dat_i  in  32  Wishbone read data
- iwb_ack_i  in  1  Wishbone acknowledge
- ins_o  out  32  latched instruction word
- ins_ack_o  out  1  one-cycle pulse: ins_o was updated
- ena_o  out  1  one-cycle pipeline advance pulse
- pha_o  out  1  thread phase; toggles on every ena_o pulse
- tmo_o  out  1  sticky bus-timeout flag

Behaviour:
- Outputs are registered except iwb_wre_o and iwb_sel_o.
- Reset (rst_i==0 at a clock edge) forces:
  - state=IDLE, wait count=0
  - iwb_stb_o=0, iwb_adr_o=0
  - ins_o=0, ins_ack_o=0
  - ena_o=0, pha_o=0, tmo_o=0
- Reset mid-cycle: iwb_stb_o drops at that edge. A late ack is ignored.
- FSM states: IDLE, BUSY, HOLD.
- IDLE:
  - If fet_req_i: iwb_adr_o<=fet_adr_i, iwb_stb_o<=1, wait count<=0, go to BUSY.
  - iwb_ack_i in IDLE is spurious and ignored.
- BUSY:
  - iwb_adr_o stays stable while iwb_stb_o=1. fet_req_i is ignored.
  - On iwb_ack_i: iwb_stb_o<=0, ins_o<=iwb_dat_i, ins_ack_o<=1.
    - If hld_i==0: ena_o<=1, pha_o<=~pha_o, go to IDLE.
    - If hld_i==1: go to HOLD.
  - Without ack: wait count increments, saturating at 8 bits.
  - Timeout: when TMO!=0 and wait count==TMO-1 with no ack:
    - iwb_stb_o<=0, ins_o<=NOP, ins_ack_o<=1, tmo_o<=1.
    - Then ena/HOLD handling exactly as for an ack.
  - Ack and timeout in the same cycle: ack wins, tmo_o unchanged.
- HOLD:
  - ins_o is retained.
  - When hld_i==0: ena_o<=1, pha_o toggles, go to IDLE.
- Pulses: ins_ack_o and ena_o are single-cycle (cleared the next cycle).
- tmo_o is cleared only by reset.
- Latency: fet_req_i at edge n gives stb at n+1. With a zero-wait ack at n+1, ins_o, ins_ack_o and ena_o are valid after edge n+2. Each wait state adds 1 cycle.
- Throughput: at most one fetch per 2 cycles; back-to-back when fet_req_i is held high.

Decomposition:
- Shared package aemb2_pkg holds:
  - the FSM state encoding: IDLE=2'd0, BUSY=2'd1, HOLD=2'd2
  - the default NOP opcode constant
  - the Wishbone select constant 4'hF
- Natural sub-module aemb2_tmo_cnt: 8-bit saturating wait counter with clear, enable, and an equality output against TMO.

Test Plan:
- Zero-wait fetch: fet_adr_i=30'h100, fet_req_i=1, ack in the cycle stb rises with dat=32'hB0000010 -> iwb_adr_o=30'h100; ins_o=32'hB0000010; ins_ack_o and ena_o each high exactly 1 cycle; pha_o 0->1.
- Wait states: ack 3 cycles after stb -> stb held 4 cycles with address stable; ena_o pulse 1 cycle after ack; no early ins_ack_o.
- Hold: hld_i=1 across ack, released 5 cycles later -> ins_ack_o at ack; ins_o stable throughout; ena_o pulses 1 cycle after hld_i falls; pha_o toggles once.
- Timeout with TMO=16 and no ack -> stb drops after 16 cycles; ins_o=32'h80000000; tmo_o=1 and remains 1 over later good fetches.
- Ack on the same cycle as the timeout -> ins_o=iwb_dat_i, tmo_o stays 0.
- Reset asserted (rst_i=0) while BUSY -> next edge: stb=0, pha_o=0, state IDLE; a following stray ack produces no ins_ack_o.

Source files
------------

// File: rtl/aemb2_pkg.sv
// Shared definitions for the aeMB2 instruction-fetch front end.
package aemb2_pkg;

   localparam int unsigned CNT_W  = 8;
   localparam logic [31:0] NOP_OP = 32'h8000_0000;
   localparam logic [3:0]  WB_SEL = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/aemb2_tmo_cnt.sv
// Saturating bus wait counter; hit_c_o flags the last permitted wait cycle.
module aemb2_tmo_cnt
   import aemb2_pkg::*;
#(
   parameter int unsigned TMO = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic ena_i,
   output logic hit_c_o
);

   localparam logic [CNT_W-1:0] TMO_HIT = CNT_W'((TMO == 0) ? 0 : TMO - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (ena_i && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // A zero TMO disables the abort entirely.
   assign hit_c_o = (TMO != 0) && (cnt_q == TMO_HIT);

endmodule

// File: rtl/aemb2_iwb_fetch.sv
// Instruction Wishbone fetch: single-beat reads, instruction latch,
// pipeline enable/phase generation and dead-slave timeout with NOP injection.
module aemb2_iwb_fetch
   import aemb2_pkg::*;
#(
   parameter int unsigned IWB = 32,
   parameter int unsigned TMO = 16,
   parameter logic [31:0] NOP = NOP_OP
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [IWB-1:2] fet_adr_i,
   input  logic           fet_req_i,
   input  logic           hld_i,
   output logic [IWB-1:2] iwb_adr_o,
   output logic           iwb_stb_o,
   output logic           iwb_wre_o,
   output logic [3:0]     iwb_sel_o,
   input  logic [31:0]    iwb_dat_i,
   input  logic           iwb_ack_i,
   output logic [31:0]    ins_o,
   output logic           ins_ack_o,
   output logic           ena_o,
   output logic           pha_o,
   output logic           tmo_o
);

   state_e         state_q, state_d;
   logic [IWB-1:2] adr_q, adr_d;
   logic           stb_q, stb_d;
   logic [31:0]    ins_q, ins_d;
   logic           ins_ack_q, ins_ack_d;
   logic           ena_q, ena_d;
   logic           pha_q, pha_d;
   logic           tmo_q, tmo_d;
   logic           cnt_clr, cnt_ena, tmo_hit;
   logic           done;

   aemb2_tmo_cnt #(.TMO(TMO)) u_tmo_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .clr_i   (cnt_clr),
      .ena_i   (cnt_ena),
      .hit_c_o (tmo_hit)
   );

   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      stb_d     = stb_q;
      ins_d     = ins_q;
      ins_ack_d = 1'b0;
      ena_d     = 1'b0;
      pha_d     = pha_q;
      tmo_d     = tmo_q;
      cnt_clr   = 1'b0;
      cnt_ena   = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (fet_req_i) begin
               adr_d   = fet_adr_i;
               stb_d   = 1'b1;
               cnt_clr = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Ack takes priority over a coincident timeout.
            if (iwb_ack_i) begin
               stb_d     = 1'b0;
               ins_d     = iwb_dat_i;
               ins_ack_d = 1'b1;
               done      = 1'b1;
            end else if (tmo_hit) begin
               stb_d     = 1'b0;
               ins_d     = NOP;
               ins_ack_d = 1'b1;
               tmo_d     = 1'b1;
               done      = 1'b1;
            end else begin
               cnt_ena = 1'b1;
            end
            if (done) begin
               if (hld_i) begin
                  state_d = HOLD;
               end else begin
                  ena_d   = 1'b1;
                  pha_d   = ~pha_q;
                  state_d = IDLE;
               end
            end
         end
         HOLD: begin
            if (!hld_i) begin
               ena_d   = 1'b1;
               pha_d   = ~pha_q;
               state_d = IDLE;
            end
         end
         default: begin
            stb_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         adr_q     <= '0;
         stb_q     <= 1'b0;
         ins_q     <= '0;
         ins_ack_q <= 1'b0;
         ena_q     <= 1'b0;
         pha_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         stb_q     <= stb_d;
         ins_q     <= ins_d;
         ins_ack_q <= ins_ack_d;
         ena_q     <= ena_d;
         pha_q     <= pha_d;
         tmo_q     <= tmo_d;
      end
   end

   assign iwb_adr_o = adr_q;
   assign iwb_stb_o = stb_q;
   assign iwb_wre_o = 1'b0;
   assign iwb_sel_o = WB_SEL;
   assign ins_o     = ins_q;
   assign ins_ack_o = ins_ack_q;
   assign ena_o     = ena_q;
   assign pha_o     = pha_q;
   assign tmo_o     = tmo_q;

endmodule

// File: tb/tb_aemb2_iwb_fetch.sv
// Directed self-checking bench for aemb2_iwb_fetch (TMO=16).
module tb_aemb2_iwb_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [29:0] fet_adr = '0;
   logic        fet_req = 1'b0;
   logic        hld = 1'b0;
   logic [29:0] iwb_adr;
   logic        iwb_stb, iwb_wre;
   logic [3:0]  iwb_sel;
   logic [31:0] iwb_dat = '0;
   logic        iwb_ack = 1'b0;
   logic [31:0] ins;
   logic        ins_ack, ena, pha, tmo;

   int total = 0;
   int bad   = 0;
   logic exp_pha = 1'b0;

   aemb2_iwb_fetch #(.IWB(32), .TMO(16), .NOP(32'h8000_0000)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .fet_adr_i (fet_adr),
      .fet_req_i (fet_req),
      .hld_i     (hld),
      .iwb_adr_o (iwb_adr),
      .iwb_stb_o (iwb_stb),
      .iwb_wre_o (iwb_wre),
      .iwb_sel_o (iwb_sel),
      .iwb_dat_i (iwb_dat),
      .iwb_ack_i (iwb_ack),
      .ins_o     (ins),
      .ins_ack_o (ins_ack),
      .ena_o     (ena),
      .pha_o     (pha),
      .tmo_o     (tmo)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      total++; if (iwb_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", iwb_stb); end
      total++; if (iwb_adr !== 30'h0) begin bad++; $display("FAIL reset_adr: got %h want 0", iwb_adr); end
      total++; if (ins !== 32'h0) begin bad++; $display("FAIL reset_ins: got %h want 0", ins); end
      total++; if ({ins_ack, ena, pha, tmo} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {ins_ack, ena, pha, tmo}); end
      total++; if ({iwb_wre, iwb_sel} !== 5'b0_1111) begin bad++; $display("FAIL reset_wre_sel: got %b want 01111", {iwb_wre, iwb_sel}); end
      rst = 1'b1;
      exp_pha = 1'b0;
      step();
   endtask

   task automatic test_zero_wait();
      fet_adr = 30'h100; fet_req = 1'b1;
      step();
      fet_req = 1'b0;
      total++; if ({iwb_stb, iwb_adr} !== {1'b1, 30'h100}) begin bad++; $display("FAIL zw_stb_adr: got %b/%h want 1/100", iwb_stb, iwb_adr); end
      total++; if ({ins_ack, ena} !== 2'b00) begin bad++; $display("FAIL zw_early: got %b want 00", {ins_ack, ena}); end
      iwb_ack = 1'b1; iwb_dat = 32'hB000_0010;
      step();
      iwb_ack = 1'b0;
      exp_pha = ~exp_pha;
      total++; if (ins !== 32'hB000_0010) begin bad++; $display("FAIL zw_ins: got %h want b0000010", ins); end
      total++; if ({iwb_stb, ins_ack, ena, pha} !== {3'b011, exp_pha}) begin bad++; $display("FAIL zw_pulse: got %b want 011%b", {iwb_stb, ins_ack, ena, pha}, exp_pha); end
      step();
      total++; if ({ins_ack, ena, pha} !== {2'b00, exp_pha}) begin bad++; $display("FAIL zw_clear: got %b want 00%b", {ins_ack, ena, pha}, exp_pha); end
      total++; if (ins !== 32'hB000_0010) begin bad++; $display("FAIL zw_ins_keep: got %h want b0000010", ins); end
   endtask

   task automatic test_wait_states();
      fet_adr = 30'h2A5; fet_req = 1'b1;
      step();
      fet_req = 1'b0; fet_adr = 30'h3FF;
      iwb_dat = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if ({iwb_stb, iwb_adr} !== {1'b1, 30'h2A5}) begin bad++; $display("FAIL ws_hold_%0d: got %b/%h want 1/2a5", i, iwb_stb, iwb_adr); end
         total++; if ({ins_ack, ena} !== 2'b00) begin bad++; $display("FAIL ws_early_%0d: got %b want 00", i, {ins_ack, ena}); end
      end
      iwb_ack = 1'b1;
      step();
      iwb_ack = 1'b0;
      exp_pha = ~exp_pha;
      total++; if ({iwb_stb, ins_ack, ena, pha} !== {3'b011, exp_pha}) begin bad++; $display("FAIL ws_done: got %b want 011%b", {iwb_stb, ins_ack, ena, pha}, exp_pha); end
      total++; if (ins !== 32'h1234_5678) begin bad++; $display("FAIL ws_ins: got %h want 12345678", ins); end
      step();
   endtask

   task automatic test_hold();
      hld = 1'b1;
      fet_adr = 30'h3; fet_req = 1'b1;
      step();
      fet_req = 1'b0;
      iwb_ack = 1'b1; iwb_dat = 32'hCAFE_F00D;
      step();
      iwb_ack = 1'b0; iwb_dat = 32'hDEAD_BEEF;
      total++; if ({iwb_stb, ins_ack, ena, pha} !== {3'b010, exp_pha}) begin bad++; $display("FAIL hold_ack: got %b want 010%b", {iwb_stb, ins_ack, ena, pha}, exp_pha); end
      total++; if (ins !== 32'hCAFE_F00D) begin bad++; $display("FAIL hold_ins: got %h want cafef00d", ins); end
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if ({ins, ins_ack, ena, pha} !== {32'hCAFE_F00D, 2'b00, exp_pha}) begin bad++; $display("FAIL hold_wait_%0d: got %h/%b want cafef00d/00%b", i, ins, {ins_ack, ena, pha}, exp_pha); end
      end
      hld = 1'b0;
      step();
      exp_pha = ~exp_pha;
      total++; if ({ins_ack, ena, pha} !== {2'b01, exp_pha}) begin bad++; $display("FAIL hold_release: got %b want 01%b", {ins_ack, ena, pha}, exp_pha); end
      step();
      total++; if ({ena, pha} !== {1'b0, exp_pha}) begin bad++; $display("FAIL hold_after: got %b want 0%b", {ena, pha}, exp_pha); end
   endtask

   task automatic test_timeout();
      fet_adr = 30'h55; fet_req = 1'b1;
      step();
      fet_req = 1'b0;
      for (int i = 1; i < 16; i++) step();
      total++; if ({iwb_stb, ins_ack, tmo} !== 3'b100) begin bad++; $display("FAIL tmo_before: got %b want 100", {iwb_stb, ins_ack, tmo}); end
      step();
      exp_pha = ~exp_pha;
      total++; if ({iwb_stb, ins_ack, ena, tmo, pha} !== {4'b0111, exp_pha}) begin bad++; $display("FAIL tmo_fire: got %b want 0111%b", {iwb_stb, ins_ack, ena, tmo, pha}, exp_pha); end
      total++; if (ins !== 32'h8000_0000) begin bad++; $display("FAIL tmo_nop: got %h want 80000000", ins); end
      // A good fetch afterwards leaves the sticky flag set.
      fet_adr = 30'h60; fet_req = 1'b1;
      step();
      fet_req = 1'b0;
      iwb_ack = 1'b1; iwb_dat = 32'h1111_1111;
      step();
      iwb_ack = 1'b0;
      exp_pha = ~exp_pha;
      total++; if ({ins, tmo} !== {32'h1111_1111, 1'b1}) begin bad++; $display("FAIL tmo_sticky: got %h/%b want 11111111/1", ins, tmo); end
      step();
      total++; if (tmo !== 1'b1) begin bad++; $display("FAIL tmo_sticky2: got %b want 1", tmo); end
   endtask

   task automatic test_reset_busy();
      fet_adr = 30'h77; fet_req = 1'b1;
      step();
      fet_req = 1'b0;
      total++; if (iwb_stb !== 1'b1) begin bad++; $display("FAIL rb_stb_up: got %b want 1", iwb_stb); end
      rst = 1'b0;
      step();
      rst = 1'b1;
      exp_pha = 1'b0;
      total++; if ({iwb_stb, pha, tmo, ins_ack} !== 4'b0000) begin bad++; $display("FAIL rb_reset: got %b want 0000", {iwb_stb, pha, tmo, ins_ack}); end
      iwb_ack = 1'b1; iwb_dat = 32'h9999_9999;
      step();
      iwb_ack = 1'b0;
      total++; if ({iwb_stb, ins_ack, ena} !== 3'b000) begin bad++; $display("FAIL rb_stray_ack: got %b want 000", {iwb_stb, ins_ack, ena}); end
      total++; if (ins !== 32'h0) begin bad++; $display("FAIL rb_ins: got %h want 0", ins); end
   endtask

   task automatic test_back_to_back();
      fet_adr = 30'h200; fet_req = 1'b1;
      iwb_dat = 32'h0000_00A1;
      step();
      iwb_ack = 1'b1;
      step();
      iwb_ack = 1'b0;
      exp_pha = ~exp_pha;
      total++; if ({iwb_stb, ins_ack, ena, ins} !== {3'b011, 32'h0000_00A1}) begin bad++; $display("FAIL b2b_first: got %b/%h want 011/000000a1", {iwb_stb, ins_ack, ena}, ins); end
      fet_adr = 30'h201;
      step();
      total++; if ({iwb_stb, iwb_adr, ins_ack, ena} !== {1'b1, 30'h201, 2'b00}) begin bad++; $display("FAIL b2b_second_stb: got %b/%h/%b want 1/201/00", iwb_stb, iwb_adr, {ins_ack, ena}); end
      fet_req = 1'b0;
      iwb_ack = 1'b1; iwb_dat = 32'h0000_00A2;
      step();
      iwb_ack = 1'b0;
      exp_pha = ~exp_pha;
      total++; if ({ins, ena, pha} !== {32'h0000_00A2, 1'b1, exp_pha}) begin bad++; $display("FAIL b2b_second: got %h/%b want 000000a2/1%b", ins, {ena, pha}, exp_pha); end
      step();
   endtask

   task automatic test_ack_at_timeout();
      fet_adr = 30'h88; fet_req = 1'b1;
      step();
      fet_req = 1'b0;
      for (int i = 1; i < 16; i++) step();
      iwb_ack = 1'b1; iwb_dat = 32'hA5A5_A5A5;
      step();
      iwb_ack = 1'b0;
      exp_pha = ~exp_pha;
      total++; if (ins !== 32'hA5A5_A5A5) begin bad++; $display("FAIL race_ins: got %h want a5a5a5a5", ins); end
      total++; if ({iwb_stb, ins_ack, ena, tmo, pha} !== {4'b0110, exp_pha}) begin bad++; $display("FAIL race_flags: got %b want 0110%b", {iwb_stb, ins_ack, ena, tmo, pha}, exp_pha); end
      step();
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_hold();
      test_timeout();
      test_reset_busy();
      test_back_to_back();
      test_ack_at_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
